ddr_burst_cmd_gen: RTL

//  Upstream feeder of the DDR instruction CDC FIFO, in the sys_clk_200M domain.

---
 rtl/ddr_cmd_pkg.sv | 18 +
 rtl/ddr_burst_len_calc.sv | 23 ++
 rtl/ddr_burst_cmd_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR instruction command path: FSM state encoding
// and default geometry of the op entries handed to the CDC FIFO.
package ddr_cmd_pkg;

  localparam int ADDR_W_DEF = 26;   // word address, one word = one 512b beat
  localparam int DATA_W_DEF = 512;  // beat width
  localparam int BL_W_DEF   = 7;    // burst-size field width
  localparam int MAX_BL_DEF = 64;   // max beats per burst, power of two
  localparam int LEN_W_DEF  = 16;   // request length width in beats

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_BEAT = 2'd2,
    DONE    = 2'd3
  } cmd_state_e;

endpackage

// File: rtl/ddr_burst_len_calc.sv
// Combinational burst length: the smaller of the remaining beats and the
// distance to the next MAX_BL-aligned boundary, so no burst crosses one.
module ddr_burst_len_calc #(
  parameter int LEN_W  = 16,
  parameter int BL_W   = 7,
  parameter int MAX_BL = 64
) (
  input  logic [$clog2(MAX_BL)-1:0] addr_off,
  input  logic [LEN_W-1:0]          rem,
  output logic [BL_W-1:0]           bl
);

  logic [LEN_W:0] room;
  logic [LEN_W:0] rem_ext;

  // room is 1..MAX_BL, so it always fits the burst-size field
  always_comb begin
    room    = (LEN_W+1)'(MAX_BL) - (LEN_W+1)'(addr_off);
    rem_ext = {1'b0, rem};
    bl      = (rem_ext < room) ? BL_W'(rem) : BL_W'(room);
  end

endmodule

// File: rtl/ddr_burst_cmd_gen.sv
// DDR burst command generator (sys_clk_200M domain). Splits one transfer
// request into boundary-safe Avalon bursts and emits one registered op entry
// per read burst or per write beat, gated by the CDC FIFO room flag.
// Optional statistics counters are built when DDR_CMD_GEN_STAT_EN is defined.
module ddr_burst_cmd_gen
  import ddr_cmd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BL_W   = BL_W_DEF,
  parameter int MAX_BL = MAX_BL_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              sys_clk_200M,
  input  logic              sys_rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_vld,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_rdy,
  input  logic              ddr_op_ins_push_vld,
  output logic              ddr_ins_op_vld,
  output logic [ADDR_W-1:0] ddr_address,
  output logic [DATA_W-1:0] ddr_write_data,
  output logic              ddr_rd_req,
  output logic              ddr_wr_req,
  output logic [BL_W-1:0]   ddr_bl_size,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stat_rd_bursts,
  output logic [31:0]       stat_wr_beats
);

  localparam int OFF_W = $clog2(MAX_BL);

  cmd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [BL_W-1:0]   beat_q;
  logic [BL_W-1:0]   bl;
  logic              accept, issue_rd, issue_wr, last_beat, last_burst;

  // addr/rem only move at burst boundaries, so bl is stable for a whole write burst
  ddr_burst_len_calc #(
    .LEN_W (LEN_W),
    .BL_W  (BL_W),
    .MAX_BL(MAX_BL)
  ) u_len_calc (
    .addr_off(addr_q[OFF_W-1:0]),
    .rem     (rem_q),
    .bl      (bl)
  );

  assign accept     = req_vld && req_rdy;
  assign issue_rd   = (state_q == RD_CMD) && ddr_op_ins_push_vld;
  assign wdata_rdy  = (state_q == WR_BEAT) && ddr_op_ins_push_vld;
  assign issue_wr   = wdata_rdy && wdata_vld;
  assign last_beat  = (beat_q == bl - 1'b1);
  assign last_burst = (rem_q == LEN_W'(bl));
  assign busy       = (state_q != IDLE);

  // State register
  always_ff @(posedge sys_clk_200M) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_len == '0) state_d = DONE;
          else if (req_wr)   state_d = WR_BEAT;
          else               state_d = RD_CMD;
        end
      end
      RD_CMD:  if (issue_rd && last_burst) state_d = DONE;
      WR_BEAT: if (issue_wr && last_beat && last_burst) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready stays low through the cycle that carries the done pulse
  always_ff @(posedge sys_clk_200M) begin
    if (sys_rst) req_rdy <= 1'b1;
    else         req_rdy <= (state_q == IDLE) && (state_d == IDLE);
  end

  // Burst address, remaining beats and beat-within-burst counters
  always_ff @(posedge sys_clk_200M) begin
    if (sys_rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      beat_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      rem_q  <= req_len;
      beat_q <= '0;
    end else if (issue_rd || (issue_wr && last_beat)) begin
      addr_q <= addr_q + ADDR_W'(bl);
      rem_q  <= rem_q - LEN_W'(bl);
      beat_q <= '0;
    end else if (issue_wr) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Registered op entry; fields hold between entries
  always_ff @(posedge sys_clk_200M) begin
    if (sys_rst) begin
      ddr_ins_op_vld <= 1'b0;
      ddr_address    <= '0;
      ddr_write_data <= '0;
      ddr_rd_req     <= 1'b0;
      ddr_wr_req     <= 1'b0;
      ddr_bl_size    <= '0;
      done           <= 1'b0;
    end else begin
      ddr_ins_op_vld <= issue_rd || issue_wr;
      done           <= (state_q == DONE);
      if (issue_rd || issue_wr) begin
        ddr_address    <= addr_q;
        ddr_write_data <= issue_wr ? wdata : '0;
        ddr_rd_req     <= issue_rd;
        ddr_wr_req     <= issue_wr;
        ddr_bl_size    <= bl;
      end
    end
  end

`ifdef DDR_CMD_GEN_STAT_EN
  // Wrapping entry counters
  always_ff @(posedge sys_clk_200M) begin
    if (sys_rst) begin
      stat_rd_bursts <= '0;
      stat_wr_beats  <= '0;
    end else begin
      if (issue_rd) stat_rd_bursts <= stat_rd_bursts + 32'd1;
      if (issue_wr) stat_wr_beats  <= stat_wr_beats + 32'd1;
    end
  end
`else
  assign stat_rd_bursts = '0;
  assign stat_wr_beats  = '0;
`endif

endmodule
